// File: rtl/mem_pkg.sv
// Shared types for the load/store access unit.
//   mem_size_t  : access size (B/H/W/D)
//   mem_err_t   : response error code
//   mau_state_t : access unit FSM state
//   size_bytes  : access size to byte count
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_TIMEOUT    = 2'd2,
      ERR_BAD_SIZE   = 2'd3
   } mem_err_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mau_state_t;

   function automatic int unsigned size_bytes(input mem_size_t s);
      return 32'd1 << s;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the access unit.
//   st_addr_lo_i/st_size_i/st_wdata_i : incoming request (store side, alignment)
//   st_wdata_o/st_wmask_o             : store data shifted into lanes, byte enables
//   st_misaligned_o                   : address not a multiple of the access size
//   ld_offset_i/ld_size_i/ld_unsigned_i/ld_rdata_i : latched load info + bus data
//   ld_data_o                         : extracted, sign/zero-extended load result
module mem_lane_align
   import mem_pkg::*;
#(
   parameter  int unsigned XLEN  = 32,
   localparam int unsigned NB    = XLEN / 8,
   localparam int unsigned OFF_W = $clog2(NB)
) (
   input  logic [2:0]       st_addr_lo_i,
   input  mem_size_t        st_size_i,
   input  logic [XLEN-1:0]  st_wdata_i,
   output logic [XLEN-1:0]  st_wdata_o,
   output logic [NB-1:0]    st_wmask_o,
   output logic             st_misaligned_o,
   input  logic [OFF_W-1:0] ld_offset_i,
   input  mem_size_t        ld_size_i,
   input  logic             ld_unsigned_i,
   input  logic [XLEN-1:0]  ld_rdata_i,
   output logic [XLEN-1:0]  ld_data_o
);

   logic [OFF_W-1:0] st_off;
   int unsigned      st_bytes;
   int unsigned      ld_bits;
   logic [XLEN-1:0]  ld_shift;
   logic             ld_sign;

   assign st_off = st_addr_lo_i[OFF_W-1:0];

   always_comb begin
      st_bytes        = size_bytes(st_size_i);
      // Uses three address bits so a D access is checked even on a 32-bit bus.
      st_misaligned_o = ((32'(st_addr_lo_i) & (st_bytes - 32'd1)) != 32'd0);
      st_wdata_o      = st_wdata_i << {st_off, 3'b000};
      st_wmask_o      = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         st_wmask_o[i] = (i >= 32'(st_off)) && (i < 32'(st_off) + st_bytes);
      end
   end

   // Sign bit and fill are located by loops so no variable index can run
   // past XLEN when the load is as wide as the bus.
   always_comb begin
      ld_bits   = 32'd8 * size_bytes(ld_size_i);
      ld_shift  = ld_rdata_i >> {ld_offset_i, 3'b000};
      ld_sign   = 1'b0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         if (i == ld_bits - 32'd1) ld_sign = ld_shift[i];
      end
      ld_data_o = ld_shift;
      for (int unsigned i = 0; i < XLEN; i++) begin
         if (i >= ld_bits) ld_data_o[i] = ld_sign & ~ld_unsigned_i;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit between the core and a single-port memory bus.
//   req_*  : core request handshake (valid/ready, write, size, unsigned, addr, wdata)
//   resp_* : one-cycle response strobe with extended load data and error code
//   mem_*  : registered bus strobes, aligned address, lane data and byte mask;
//            mem_resp/mem_rdata return the single-cycle completion
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic [1:0]          resp_err,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wmask,
   output logic                mem_read,
   output logic                mem_write,
   input  logic                mem_resp,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   mau_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]     wmask_q, wmask_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              rvalid_q, rvalid_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   mem_err_t          err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_size_t         size_q, size_d;
   logic              uns_q, uns_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              is_st_q, is_st_d;

   mem_size_t         req_sz;
   logic [XLEN-1:0]   lane_wdata;
   logic [NB-1:0]     lane_wmask;
   logic              misaligned;
   logic [XLEN-1:0]   ld_data;
   logic              bad_size;
   logic [CNT_W-1:0]  cnt_inc;

   assign req_sz   = mem_size_t'(req_size);
   assign bad_size = (req_sz == SZ_D) && (XLEN < 64);

   mem_lane_align #(
      .XLEN (XLEN)
   ) u_lane (
      .st_addr_lo_i    (req_addr[2:0]),
      .st_size_i       (req_sz),
      .st_wdata_i      (req_wdata),
      .st_wdata_o      (lane_wdata),
      .st_wmask_o      (lane_wmask),
      .st_misaligned_o (misaligned),
      .ld_offset_i     (off_q),
      .ld_size_i       (size_q),
      .ld_unsigned_i   (uns_q),
      .ld_rdata_i      (mem_rdata),
      .ld_data_o       (ld_data)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      read_d   = read_q;
      write_d  = write_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      uns_d    = uns_q;
      off_d    = off_q;
      is_st_d  = is_st_q;
      cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (bad_size || misaligned) begin
                  state_d  = ST_RESP;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  err_d    = bad_size ? ERR_BAD_SIZE : ERR_MISALIGNED;
               end else begin
                  state_d = ST_ACCESS;
                  addr_d  = req_addr & ~ADDR_W'(NB - 1);
                  wdata_d = req_write ? lane_wdata : '0;
                  wmask_d = req_write ? lane_wmask : '1;
                  read_d  = ~req_write;
                  write_d = req_write;
                  size_d  = req_sz;
                  uns_d   = req_unsigned;
                  off_d   = req_addr[OFF_W-1:0];
                  is_st_d = req_write;
                  cnt_d   = '0;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_inc;
            // A response in the same cycle the count reaches TIMEOUT wins.
            if (mem_resp) begin
               state_d  = ST_RESP;
               read_d   = 1'b0;
               write_d  = 1'b0;
               rvalid_d = 1'b1;
               rdata_d  = is_st_q ? '0 : ld_data;
               err_d    = ERR_NONE;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               state_d  = ST_RESP;
               read_d   = 1'b0;
               write_d  = 1'b0;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               err_d    = ERR_TIMEOUT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= ERR_NONE;
         cnt_q    <= '0;
         size_q   <= SZ_B;
         uns_q    <= 1'b0;
         off_q    <= '0;
         is_st_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         read_q   <= read_d;
         write_q  <= write_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         off_q    <= off_d;
         is_st_q  <= is_st_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = rvalid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wmask  = wmask_q;
   assign mem_read   = read_q;
   assign mem_write  = write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // 32-bit instance, TIMEOUT = 4
   logic        a_valid, a_ready, a_write, a_uns, a_rv, a_mread, a_mwrite, a_mresp;
   logic [1:0]  a_size, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata, a_maddr, a_mwdata, a_mrdata;
   logic [3:0]  a_mmask;

   // 64-bit instance, TIMEOUT = 8
   logic        b_valid, b_ready, b_write, b_uns, b_rv, b_mread, b_mwrite, b_mresp;
   logic [1:0]  b_size, b_err;
   logic [31:0] b_addr, b_maddr;
   logic [63:0] b_wdata, b_rdata, b_mwdata, b_mrdata;
   logic [7:0]  b_mmask;

   mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write), .req_size(a_size),
      .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
      .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
      .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mmask),
      .mem_read(a_mread), .mem_write(a_mwrite), .mem_resp(a_mresp), .mem_rdata(a_mrdata)
   );

   mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write), .req_size(b_size),
      .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
      .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
      .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mmask),
      .mem_read(b_mread), .mem_write(b_mwrite), .mem_resp(b_mresp), .mem_rdata(b_mrdata)
   );

   // Issue one request on the 32-bit unit; mem_resp is driven in strobe cycle
   // resp_at (0 = never). Returns cycles from acceptance to resp_valid (0 if
   // the bound expired) and a snapshot of the bus at the first strobe cycle.
   task automatic run32(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int resp_at,
                        output int lat, output int strobes,
                        output logic [31:0] a_seen, output logic [3:0] m_seen,
                        output logic [31:0] wd_seen, output logic wr_seen);
      lat = 0; strobes = 0; a_seen = '0; m_seen = '0; wd_seen = '0; wr_seen = 1'b0;
      @(negedge clk);
      a_valid = 1'b1; a_write = wr; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd;
      @(negedge clk);
      a_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (a_rv) begin
            lat = k;
            break;
         end
         if (a_mread || a_mwrite) begin
            strobes++;
            if (strobes == 1) begin
               a_seen = a_maddr; m_seen = a_mmask; wd_seen = a_mwdata; wr_seen = a_mwrite;
            end
         end
         a_mresp  = (k == resp_at);
         a_mrdata = rd;
      end
      a_mresp = 1'b0;
   endtask

   task automatic run64(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int resp_at,
                        output int lat, output int strobes,
                        output logic [31:0] a_seen, output logic [7:0] m_seen,
                        output logic [63:0] wd_seen);
      lat = 0; strobes = 0; a_seen = '0; m_seen = '0; wd_seen = '0;
      @(negedge clk);
      b_valid = 1'b1; b_write = wr; b_size = sz; b_uns = uns; b_addr = addr; b_wdata = wd;
      @(negedge clk);
      b_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (b_rv) begin
            lat = k;
            break;
         end
         if (b_mread || b_mwrite) begin
            strobes++;
            if (strobes == 1) begin
               a_seen = b_maddr; m_seen = b_mmask; wd_seen = b_mwdata;
            end
         end
         b_mresp  = (k == resp_at);
         b_mrdata = rd;
      end
      b_mresp = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
      checks++; if ({a_rv, a_mread, a_mwrite} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {a_rv, a_mread, a_mwrite}); end
      checks++; if ({a_maddr, a_mwdata, a_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {a_maddr, a_mwdata, a_rdata}); end
      checks++; if ({a_mmask, a_err} !== 6'h0) begin errors++; $display("FAIL reset_mask_err got=%h exp=0", {a_mmask, a_err}); end
      checks++; if ({b_ready, b_rv, b_mread, b_mwrite, b_mmask} !== 12'h800) begin errors++; $display("FAIL reset_u64 got=%h exp=800", {b_ready, b_rv, b_mread, b_mwrite, b_mmask}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      run32(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 3, lat, st, as, ms, wds, ws);
      checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency got=%0d exp=4", lat); end
      checks++; if (st !== 3) begin errors++; $display("FAIL lw_strobe_cycles got=%0d exp=3", st); end
      checks++; if (as !== 32'h104) begin errors++; $display("FAIL lw_addr got=%h exp=00000104", as); end
      checks++; if (ms !== 4'hF) begin errors++; $display("FAIL lw_mask got=%h exp=f", ms); end
      checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", a_rdata); end
      checks++; if (a_err !== 2'd0) begin errors++; $display("FAIL lw_err got=%0d exp=0", a_err); end
      checks++; if (a_mread !== 1'b0) begin errors++; $display("FAIL lw_strobe_drop got=%b exp=0", a_mread); end
      @(negedge clk);
      checks++; if ({a_rv, a_ready} !== 2'b01) begin errors++; $display("FAIL lw_resp_one_cycle got=%b exp=01", {a_rv, a_ready}); end
   endtask

   task automatic test_lb_lbu();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      run32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 1, lat, st, as, ms, wds, ws);
      checks++; if (lat !== 2) begin errors++; $display("FAIL lb_min_latency got=%0d exp=2", lat); end
      checks++; if (as !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=00000100", as); end
      checks++; if (a_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h exp=ffffff80", a_rdata); end
      run32(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 1, lat, st, as, ms, wds, ws);
      checks++; if (a_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got=%h exp=00000080", a_rdata); end
      run32(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h9ABC0000, 2, lat, st, as, ms, wds, ws);
      checks++; if ({lat, a_rdata} !== {32'd3, 32'hFFFF9ABC}) begin errors++; $display("FAIL lh_sext got lat=%0d data=%h exp lat=3 data=ffff9abc", lat, a_rdata); end
   endtask

   task automatic test_store32();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      run32(1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h12345678, 1, lat, st, as, ms, wds, ws);
      checks++; if (wds !== 32'hFFFF5A00) begin errors++; $display("FAIL sb_wdata got=%h exp=ffff5a00", wds); end
      checks++; if (ms !== 4'h2) begin errors++; $display("FAIL sb_mask got=%h exp=2", ms); end
      checks++; if (ws !== 1'b1) begin errors++; $display("FAIL sb_write_strobe got=%b exp=1", ws); end
      checks++; if ({a_rdata, a_err} !== 34'h0) begin errors++; $display("FAIL sb_resp got=%h exp=0", {a_rdata, a_err}); end
      run32(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0, 1, lat, st, as, ms, wds, ws);
      checks++; if ({as, wds, ms} !== {32'h100, 32'h12340000, 4'hC}) begin errors++; $display("FAIL sh_lanes got=%h/%h/%h exp=00000100/12340000/c", as, wds, ms); end
   endtask

   task automatic test_errors();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      run32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1, lat, st, as, ms, wds, ws);
      checks++; if (lat !== 1) begin errors++; $display("FAIL misaligned_latency got=%0d exp=1", lat); end
      checks++; if (st !== 0) begin errors++; $display("FAIL misaligned_no_strobe got=%0d exp=0", st); end
      checks++; if (a_err !== 2'd1) begin errors++; $display("FAIL misaligned_err got=%0d exp=1", a_err); end
      run32(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, 32'h0, 1, lat, st, as, ms, wds, ws);
      checks++; if ({lat, st, a_err} !== {32'd1, 32'd0, 2'd3}) begin errors++; $display("FAIL bad_size got lat=%0d strobes=%0d err=%0d exp 1/0/3", lat, st, a_err); end
      checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL bad_size_rdata got=%h exp=0", a_rdata); end
   endtask

   task automatic test_timeout();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      run32(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 0, lat, st, as, ms, wds, ws);
      checks++; if (st !== 4) begin errors++; $display("FAIL timeout_strobe_cycles got=%0d exp=4", st); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL timeout_latency got=%0d exp=5", lat); end
      checks++; if (a_err !== 2'd2) begin errors++; $display("FAIL timeout_err got=%0d exp=2", a_err); end
      @(negedge clk);
      a_mresp = 1'b1;
      @(negedge clk);
      a_mresp = 1'b0;
      checks++; if ({a_rv, a_ready, a_mread} !== 3'b010) begin errors++; $display("FAIL late_resp_ignored got=%b exp=010", {a_rv, a_ready, a_mread}); end
      run32(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, 4, lat, st, as, ms, wds, ws);
      checks++; if ({lat, a_err, a_rdata} !== {32'd5, 2'd0, 32'hCAFEF00D}) begin errors++; $display("FAIL resp_beats_timeout got lat=%0d err=%0d data=%h exp 5/0/cafef00d", lat, a_err, a_rdata); end
   endtask

   task automatic test_reset_mid_access();
      int lat, st; logic [31:0] as, wds; logic [3:0] ms; logic ws;
      int rv_seen;
      @(negedge clk);
      a_valid = 1'b1; a_write = 1'b0; a_size = 2'd2; a_uns = 1'b0; a_addr = 32'h300;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      checks++; if (a_mread !== 1'b1) begin errors++; $display("FAIL pre_reset_strobe got=%b exp=1", a_mread); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({a_mread, a_ready} !== 2'b01) begin errors++; $display("FAIL reset_mid_access got=%b exp=01", {a_mread, a_ready}); end
      @(negedge clk);
      rst_n = 1'b1;
      rv_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_rv) rv_seen++;
      end
      checks++; if (rv_seen !== 0) begin errors++; $display("FAIL reset_no_resp got=%0d exp=0", rv_seen); end
      run32(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h01234567, 1, lat, st, as, ms, wds, ws);
      checks++; if ({lat, a_rdata, a_err} !== {32'd2, 32'h01234567, 2'd0}) begin errors++; $display("FAIL post_reset_access got lat=%0d data=%h err=%0d exp 2/01234567/0", lat, a_rdata, a_err); end
   endtask

   task automatic test_xlen64();
      int lat, st; logic [31:0] as; logic [63:0] wds; logic [7:0] ms;
      run64(1'b1, 2'd1, 1'b0, 32'h1006, 64'hABCD, 64'h0, 2, lat, st, as, ms, wds);
      checks++; if (as !== 32'h1000) begin errors++; $display("FAIL sh64_addr got=%h exp=00001000", as); end
      checks++; if (wds !== 64'hABCD_0000_0000_0000) begin errors++; $display("FAIL sh64_wdata got=%h exp=abcd000000000000", wds); end
      checks++; if (ms !== 8'hC0) begin errors++; $display("FAIL sh64_mask got=%h exp=c0", ms); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL sh64_latency got=%0d exp=3", lat); end
      run64(1'b0, 2'd2, 1'b0, 32'h1004, 64'h0, 64'h8000_0000_0000_0000, 1, lat, st, as, ms, wds);
      checks++; if (b_rdata !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lw64_sext got=%h exp=ffffffff80000000", b_rdata); end
      run64(1'b0, 2'd2, 1'b1, 32'h1004, 64'h0, 64'h8000_0000_0000_0000, 1, lat, st, as, ms, wds);
      checks++; if (b_rdata !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL lwu64_zext got=%h exp=0000000080000000", b_rdata); end
      run64(1'b0, 2'd1, 1'b0, 32'h1002, 64'h0, 64'h1122_3344_8765_9999, 1, lat, st, as, ms, wds);
      checks++; if (b_rdata !== 64'hFFFF_FFFF_FFFF_8765) begin errors++; $display("FAIL lh64_sext got=%h exp=ffffffffffff8765", b_rdata); end
      run64(1'b0, 2'd3, 1'b0, 32'h1008, 64'h0, 64'h8000_0000_0000_0001, 1, lat, st, as, ms, wds);
      checks++; if ({as, ms, b_rdata, b_err} !== {32'h1008, 8'hFF, 64'h8000_0000_0000_0001, 2'd0}) begin errors++; $display("FAIL ld64 got addr=%h mask=%h data=%h err=%0d", as, ms, b_rdata, b_err); end
      run64(1'b0, 2'd3, 1'b0, 32'h100C, 64'h0, 64'h0, 1, lat, st, as, ms, wds);
      checks++; if ({lat, st, b_err} !== {32'd1, 32'd0, 2'd1}) begin errors++; $display("FAIL ld64_misaligned got lat=%0d strobes=%0d err=%0d exp 1/0/1", lat, st, b_err); end
   endtask

   initial begin
      a_valid = 1'b0; a_write = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
      a_mresp = 1'b0; a_mrdata = '0;
      b_valid = 1'b0; b_write = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
      b_mresp = 1'b0; b_mrdata = '0;
      test_reset();
      test_lw();
      test_lb_lbu();
      test_store32();
      test_errors();
      test_timeout();
      test_reset_mid_access();
      test_xlen64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
